// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector for the 5-stage pipeline.
// Stalls PC and IF/ID, bubbles ID/EX, and counts stall cycles.
module load_use_hazard_unit #(
   parameter int REG_ADDR_W   = 3,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_reg_write,
   input  logic [REG_ADDR_W-1:0] if_src_a,
   input  logic [REG_ADDR_W-1:0] if_src_b,
   input  logic                  if_src_b_used,
   input  logic                  mem_wait,
   input  logic                  flush,
   output logic                  is_stall,
   output logic                  idex_bubble,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam int CW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LATENCY - 1);

   typedef enum logic {
      IDLE,
      STALL
   } state_e;

   state_e                state_q, state_d;
   logic [REG_ADDR_W-1:0] held_dest_q, held_dest_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]      stall_cycles_q;

   logic hit_id;
   logic hit_held;
   logic det;
   logic stall;

   assign hit_id = (id_dest != '0) &
                   ((if_src_a == id_dest) |
                    (if_src_b_used & (if_src_b == id_dest)));

   assign hit_held = (held_dest_q != '0) &
                     ((if_src_a == held_dest_q) |
                      (if_src_b_used & (if_src_b == held_dest_q)));

   assign det = id_mem_read & id_reg_write & hit_id;

   always_comb begin
      state_d     = state_q;
      held_dest_d = held_dest_q;
      cnt_d       = cnt_q;
      stall       = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            STALL: begin
               if ((cnt_q != '0 | mem_wait) & hit_held) begin
                  stall = 1'b1;
                  if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
               end else begin
                  state_d = IDLE;
                  // A fresh hazard on the exit cycle starts a new stall.
                  if (det) begin
                     stall       = 1'b1;
                     held_dest_d = id_dest;
                     cnt_d       = CNT_INIT;
                     if (LOAD_LATENCY > 1 || mem_wait) state_d = STALL;
                  end
               end
            end
            default: begin
               if (det) begin
                  stall       = 1'b1;
                  held_dest_d = id_dest;
                  cnt_d       = CNT_INIT;
                  if (LOAD_LATENCY > 1 || mem_wait) state_d = STALL;
               end
            end
         endcase
      end
   end

   // Outputs are forced low while reset is asserted.
   assign is_stall     = stall & rst_n;
   assign idex_bubble  = stall & rst_n;
   assign stall_cycles = stall_cycles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         held_dest_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         held_dest_q <= held_dest_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else if (is_stall && stall_cycles_q != '1) begin
         stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed self-checking bench for load_use_hazard_unit.
// Four instances share stimulus: latency 1, 2, 3 and a narrow counter.
module tb_load_use_hazard_unit;

   logic       clk;
   logic       rst_n;
   logic       id_mem_read;
   logic [2:0] id_dest;
   logic       id_reg_write;
   logic [2:0] if_src_a;
   logic [2:0] if_src_b;
   logic       if_src_b_used;
   logic       mem_wait;
   logic       flush;

   logic        st1, bb1, st2, bb2, st3, bb3, sts, bbs;
   logic [15:0] sc1, sc2, sc3;
   logic [2:0]  scs;

   int errors = 0;
   int checks = 0;

   load_use_hazard_unit #(.REG_ADDR_W(3), .LOAD_LATENCY(1), .CNT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .id_mem_read(id_mem_read),
      .id_dest(id_dest), .id_reg_write(id_reg_write),
      .if_src_a(if_src_a), .if_src_b(if_src_b),
      .if_src_b_used(if_src_b_used), .mem_wait(mem_wait),
      .flush(flush), .is_stall(st1), .idex_bubble(bb1),
      .stall_cycles(sc1));

   load_use_hazard_unit #(.REG_ADDR_W(3), .LOAD_LATENCY(2), .CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst_n), .id_mem_read(id_mem_read),
      .id_dest(id_dest), .id_reg_write(id_reg_write),
      .if_src_a(if_src_a), .if_src_b(if_src_b),
      .if_src_b_used(if_src_b_used), .mem_wait(mem_wait),
      .flush(flush), .is_stall(st2), .idex_bubble(bb2),
      .stall_cycles(sc2));

   load_use_hazard_unit #(.REG_ADDR_W(3), .LOAD_LATENCY(3), .CNT_W(16)) u3 (
      .clk(clk), .rst_n(rst_n), .id_mem_read(id_mem_read),
      .id_dest(id_dest), .id_reg_write(id_reg_write),
      .if_src_a(if_src_a), .if_src_b(if_src_b),
      .if_src_b_used(if_src_b_used), .mem_wait(mem_wait),
      .flush(flush), .is_stall(st3), .idex_bubble(bb3),
      .stall_cycles(sc3));

   load_use_hazard_unit #(.REG_ADDR_W(3), .LOAD_LATENCY(1), .CNT_W(3)) us (
      .clk(clk), .rst_n(rst_n), .id_mem_read(id_mem_read),
      .id_dest(id_dest), .id_reg_write(id_reg_write),
      .if_src_a(if_src_a), .if_src_b(if_src_b),
      .if_src_b_used(if_src_b_used), .mem_wait(mem_wait),
      .flush(flush), .is_stall(sts), .idex_bubble(bbs),
      .stall_cycles(scs));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic bu,
                        input logic mr, input logic rw);
      id_dest       = d;
      if_src_a      = a;
      if_src_b      = b;
      if_src_b_used = bu;
      id_mem_read   = mr;
      id_reg_write  = rw;
   endtask

   task automatic idle_in();
      drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      mem_wait = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      adv();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      @(negedge clk);
      chk("rst_stall", {31'd0, st1 | st2 | st3}, 32'd0);
      chk("rst_bubble", {31'd0, bb1 | bb2 | bb3}, 32'd0);
      chk("rst_cnt1", {16'd0, sc1}, 32'd0);
      chk("rst_cnt3", {16'd0, sc3}, 32'd0);
      #2;
      rst_n = 1'b1;
      adv();

      // lw r3 ; add r1,r3,r2 with latency 1
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t1_stall_c0", {31'd0, st1}, 32'd1);
      chk("t1_bubble_c0", {31'd0, bb1}, 32'd1);
      adv();
      drive(3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t1_stall_c1", {31'd0, st1}, 32'd0);
      chk("t1_cnt", {16'd0, sc1}, 32'd1);

      // latency 3
      do_reset();
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t2_stall_c0", {31'd0, st3}, 32'd1);
      adv();
      drive(3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t2_stall_c1", {31'd0, st3}, 32'd1);
      adv();
      @(negedge clk);
      chk("t2_stall_c2", {31'd0, bb3}, 32'd1);
      adv();
      @(negedge clk);
      chk("t2_stall_c3", {31'd0, st3}, 32'd0);
      adv();
      @(negedge clk);
      chk("t2_stall_c4", {31'd0, st3}, 32'd0);
      chk("t2_cnt", {16'd0, sc3}, 32'd3);
      chk("t2_cntq", {30'd0, u3.cnt_q}, 32'd0);

      // latency 2 extended by two mem_wait cycles
      do_reset();
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t3_stall_c0", {31'd0, st2}, 32'd1);
      adv();
      drive(3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t3_stall_c1", {31'd0, st2}, 32'd1);
      adv();
      mem_wait = 1'b1;
      @(negedge clk);
      chk("t3_stall_c2", {31'd0, st2}, 32'd1);
      adv();
      @(negedge clk);
      chk("t3_stall_c3", {31'd0, st2}, 32'd1);
      adv();
      mem_wait = 1'b0;
      @(negedge clk);
      chk("t3_stall_c4", {31'd0, st2}, 32'd0);
      adv();
      chk("t3_cnt", {16'd0, sc2}, 32'd4);

      // negative cases
      do_reset();
      drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_r0", {31'd0, st1 | st3}, 32'd0);
      adv();
      drive(3'd3, 3'd1, 3'd3, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_b_unused", {31'd0, st1 | st3}, 32'd0);
      adv();
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4_no_write", {31'd0, st1 | st3}, 32'd0);
      adv();
      drive(3'd5, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_fullbits", {31'd0, st1 | st3}, 32'd0);
      adv();
      drive(3'd3, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1);
      mem_wait = 1'b1;
      @(negedge clk);
      chk("t4_memwait", {31'd0, st1 | st3}, 32'd0);
      adv();
      mem_wait = 1'b0;
      drive(3'd3, 3'd1, 3'd3, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_b_used", {31'd0, st1}, 32'd1);
      adv();
      chk("t4_cnt", {16'd0, sc1}, 32'd1);

      // flush aborts a latency-3 stall
      do_reset();
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t5_stall_c0", {31'd0, st3}, 32'd1);
      adv();
      drive(3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_stall", {31'd0, st3}, 32'd0);
      chk("t5_flush_bubble", {31'd0, bb3}, 32'd0);
      adv();
      flush = 1'b0;
      chk("t5_cntq", {30'd0, u3.cnt_q}, 32'd0);
      @(negedge clk);
      chk("t5_after", {31'd0, st3}, 32'd0);
      chk("t5_cnt", {16'd0, sc3}, 32'd1);
      adv();
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_det", {31'd0, st1}, 32'd0);
      adv();

      // asynchronous reset mid-stall
      do_reset();
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      adv();
      drive(3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t6_pre", {31'd0, st3}, 32'd1);
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_stall", {31'd0, st3 | st1}, 32'd0);
      chk("t6_bubble", {31'd0, bb3 | bb1}, 32'd0);
      chk("t6_cnt", {16'd0, sc3}, 32'd0);
      idle_in();
      adv();
      rst_n = 1'b1;
      adv();
      chk("t6_cnt_after", {16'd0, sc1}, 32'd0);

      // saturation of a 3-bit counter
      drive(3'd3, 3'd3, 3'd2, 1'b1, 1'b1, 1'b1);
      repeat (7) adv();
      chk("t7_sat7", {29'd0, scs}, 32'd7);
      repeat (3) adv();
      chk("t7_sat_hold", {29'd0, scs}, 32'd7);
      chk("t7_wide", {16'd0, sc1}, 32'd10);
      idle_in();
      adv();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
